// File: rtl/mem_data.sv
// mem_data: byte-addressed little-endian data memory, combinational read, synchronous word write
module mem_data #(
  parameter int DEPTH      = 128,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_write,
  input  logic [31:0]           i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_mem_data
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  r_mem_data [0:DEPTH-1];
  logic [32:0] lane_idx [4];
  logic [3:0]  lane_ok;
  genvar k;
  for (k = 0; k < 4; k++) begin : g_lane
    assign lane_idx[k] = {1'b0, i_mem_addr} + 33'(k);
    assign lane_ok[k] = lane_idx[k] < 33'(DEPTH);
    assign o_mem_data[8*k +: 8] = lane_ok[k] ? r_mem_data[lane_idx[k][AW-1:0]] : 8'h00;
  end
  // clear everything on reset, otherwise store each in-range byte lane of a write
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      for (int i = 0; i < DEPTH; i++) r_mem_data[i] <= 8'h00;
    else if (i_mem_write == 1'b1)
      for (int j = 0; j < 4; j++)
        if (lane_ok[j]) r_mem_data[lane_idx[j][AW-1:0]] <= i_mem_data[8*j +: 8];
endmodule

// File: tb/tb_mem_data.sv
// tb_mem_data: randomized scoreboard bench for mem_data against a byte-array reference model
module tb_mem_data;
  localparam int DEPTH = 128;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  typedef struct {
    bit          is_byte;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t        exp_q[$];
  event        sample_ev;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model [DEPTH];

  mem_data #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_mem_write(we),
    .i_mem_addr(addr),
    .i_mem_data(wdata),
    .o_mem_data(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r = '0;
    for (int n = 0; n < 4; n++) begin
      longint p = longint'(a) + n;
      if (p < DEPTH) r[8*n +: 8] = model[int'(p)];
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    for (int n = 0; n < 4; n++) begin
      longint p = longint'(a) + n;
      if (p < DEPTH) model[int'(p)] = d[8*n +: 8];
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < DEPTH; n++) model[n] = 8'h00;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    e.is_byte = 1'b0;
    e.idx = 0;
    e.exp = model_read(addr);
    e.name = name;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic check_byte(input string name, input int idx);
    exp_t e;
    e.is_byte = 1'b1;
    e.idx = idx;
    e.exp = {24'h0, model[idx]};
    e.name = name;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic dump(input string name, input int lo, input int hi);
    for (int n = lo; n <= hi; n++) check_byte(name, n);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    if (!rst) model_write(a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic read_at(input string name, input logic [31:0] a);
    addr = a;
    #1;
    check_out(name);
  endtask

  // monitor: pop the oldest expectation each time a sample is presented and compare
  initial forever begin
    exp_t e;
    logic [31:0] act;
    @(sample_ev);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = e.is_byte ? {24'h0, dut.r_mem_data[e.idx]} : rdata;
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s idx=%0d addr=%h actual=%h expected=%h", e.name, e.idx, addr, act, e.exp);
      end
    end
  end

  initial begin
    model_clear();
    rst = 1'b1;
    #1;
    check_out("rst_during");
    #9;
    rst = 1'b0;
    #1;
    dump("rst_dump", 0, 115);
    read_at("rst_read0", 32'd0);
    do_write(32'd8, 32'hFEFEEFEF);
    dump("w8_dump", 8, 12);
    read_at("w8_read", 32'd8);
    do_write(32'd5, 32'h11223344);
    dump("w5_dump", 5, 9);
    read_at("r6_unaligned", 32'd6);
    do_write(32'd126, 32'hAABBCCDD);
    dump("w126_dump", 124, 127);
    dump("w126_nowrap", 0, 3);
    read_at("r126_edge", 32'd126);
    read_at("r_fffffffc", 32'hFFFFFFFC);
    read_at("r_ffffffff", 32'hFFFFFFFF);
    read_at("r127", 32'd127);
    @(negedge clk);
    addr = 32'd8;
    for (int n = 0; n < 4; n++) begin
      wdata = $urandom;
      @(posedge clk);
      #1;
      check_out("we0_hold");
    end
    dump("we0_dump", 0, DEPTH-1);
    do_write(32'd16, 32'h01020304);
    @(negedge clk);
    addr = 32'd16;
    wdata = 32'h0A0B0C0D;
    we = 1'b1;
    #1;
    check_out("rdw_before");
    @(posedge clk);
    model_write(32'd16, 32'h0A0B0C0D);
    #1;
    we = 1'b0;
    check_out("rdw_after");
    do_write(32'd40, 32'hCAFEBABE);
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    dump("rst_mid", 0, DEPTH-1);
    @(negedge clk);
    addr = 32'd20;
    wdata = 32'h55AA55AA;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    dump("wr_in_rst", 18, 25);
    check_out("wr_in_rst_read");
    rst = 1'b0;
    #1;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom_range(0, DEPTH + 3);
      wdata = $urandom;
      we = $urandom_range(0, 1) == 1;
      #1;
      check_out("rnd_pre");
      @(posedge clk);
      if (we) model_write(addr, wdata);
      #1;
      we = 1'b0;
      check_out("rnd_post");
    end
    dump("final_dump", 0, DEPTH-1);
    #5;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
